// File: rtl/drive_cmd_if.sv
// Drive command scheduler bus: manual/autonomous command handshakes, proximity blocks,
// and the scheduled command with its status flags.
interface drive_cmd_if;
    logic        man_valid;
    logic [10:0] man_val;
    logic        man_ready;
    logic        auto_en;
    logic        auto_valid;
    logic [10:0] auto_val;
    logic        auto_ready;
    logic        block_fwd;
    logic        block_rev;
    logic [10:0] x_cmd;
    logic        src_sel;
    logic        at_target;
    logic        timeout_flag;

    modport master (
        output man_valid, man_val, auto_en, auto_valid, auto_val, block_fwd, block_rev,
        input  man_ready, auto_ready, x_cmd, src_sel, at_target, timeout_flag
    );

    modport slave (
        input  man_valid, man_val, auto_en, auto_valid, auto_val, block_fwd, block_rev,
        output man_ready, auto_ready, x_cmd, src_sel, at_target, timeout_flag
    );
endinterface

// File: rtl/drive_cmd_sched.sv
// Drive/steering command scheduler: manual-priority arbitration, clamping, slew limiting,
// proximity blocking with emergency stop, and a watchdog that falls back to neutral.
module drive_cmd_sched #(
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned STEP          = 10,
    parameter int unsigned TIMEOUT_TICKS = 250,
    parameter int unsigned NEUTRAL       = 1500,
    parameter int unsigned MIN_VAL       = 1000,
    parameter int unsigned MAX_VAL       = 2000
) (
    input logic        clk,
    input logic        rst,
    drive_cmd_if.slave bus
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WdogW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    localparam logic [10:0]        NeutralV = 11'(NEUTRAL);
    localparam logic [10:0]        MinV     = 11'(MIN_VAL);
    localparam logic [10:0]        MaxV     = 11'(MAX_VAL);
    localparam logic [10:0]        StepV    = 11'(STEP);
    localparam logic signed [11:0] StepS    = 12'(STEP);
    localparam logic [TickW-1:0]   TickLast = TickW'(TICK_DIV - 1);
    localparam logic [WdogW-1:0]   WdogLast = WdogW'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StFailsafe
    } state_e;

    function automatic logic [10:0] clamp(input logic [10:0] v);
        logic [10:0] r;
        r = v;
        if (v < MinV) begin
            r = MinV;
        end else if (v > MaxV) begin
            r = MaxV;
        end
        return r;
    endfunction

    // Blocking only restricts the direction of travel; the stored target is left intact.
    function automatic logic [10:0] eff_of(input logic [10:0] tgt, input logic bf,
                                           input logic br);
        logic [10:0] r;
        r = tgt;
        if (bf && br) begin
            r = NeutralV;
        end else if (bf && (tgt > NeutralV)) begin
            r = NeutralV;
        end else if (br && (tgt < NeutralV)) begin
            r = NeutralV;
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [10:0]       target_q, target_d;
    logic [10:0]       x_cmd_q, x_cmd_d;
    logic              src_sel_q, src_sel_d;
    logic              at_target_q, at_target_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;

    logic              tick;
    logic              man_acc;
    logic              auto_acc;
    logic              accept;
    logic [10:0]       raw_val;
    logic [10:0]       eff;
    logic signed [11:0] diff;
    logic              estop;

    assign bus.man_ready  = ~rst;
    assign bus.auto_ready = bus.auto_en & ~bus.man_valid;

    assign man_acc  = bus.man_valid & bus.man_ready;
    assign auto_acc = bus.auto_valid & bus.auto_ready;
    assign accept   = man_acc | auto_acc;
    assign raw_val  = man_acc ? bus.man_val : bus.auto_val;

    assign tick  = (tick_cnt_q == TickLast);
    assign eff   = eff_of(target_q, bus.block_fwd, bus.block_rev);
    assign diff  = $signed({1'b0, eff}) - $signed({1'b0, x_cmd_q});
    assign estop = (bus.block_fwd && (x_cmd_q > NeutralV)) ||
                   (bus.block_rev && (x_cmd_q < NeutralV));

    // Arbitration, target registration and watchdog.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        src_sel_d  = src_sel_q;
        wdog_d     = wdog_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        if (accept) begin
            state_d   = StTrack;
            target_d  = clamp(raw_val);
            src_sel_d = auto_acc;
            wdog_d    = '0;
        end else begin
            unique case (state_q)
                StTrack: begin
                    if (tick) begin
                        if (wdog_q == WdogLast) begin
                            state_d  = StFailsafe;
                            target_d = NeutralV;
                            wdog_d   = '0;
                        end else begin
                            wdog_d = wdog_q + 1'b1;
                        end
                    end
                end
                default: wdog_d = '0;
            endcase
        end
    end

    // Emergency stop overrides slew; otherwise move at most STEP per tick.
    always_comb begin
        x_cmd_d = x_cmd_q;
        if (estop) begin
            x_cmd_d = NeutralV;
        end else if (tick) begin
            if (diff > StepS) begin
                x_cmd_d = x_cmd_q + StepV;
            end else if (diff < -StepS) begin
                x_cmd_d = x_cmd_q - StepV;
            end else begin
                x_cmd_d = eff;
            end
        end
        at_target_d = (x_cmd_d == eff_of(target_d, bus.block_fwd, bus.block_rev));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            target_q    <= NeutralV;
            x_cmd_q     <= NeutralV;
            src_sel_q   <= 1'b0;
            at_target_q <= 1'b1;
            tick_cnt_q  <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            x_cmd_q     <= x_cmd_d;
            src_sel_q   <= src_sel_d;
            at_target_q <= at_target_d;
            tick_cnt_q  <= tick_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.x_cmd        = x_cmd_q;
    assign bus.src_sel      = src_sel_q;
    assign bus.at_target    = at_target_q;
    assign bus.timeout_flag = (state_q == StFailsafe);

endmodule
